// File: rtl/hacd_pkg.sv
// Shared AXI write-side packet types and write-arbiter definitions for the hawk page-write path.
package hacd_pkg;

  localparam int HAWK_AXI_ADDR_W = 40;
  localparam int HAWK_AXI_DATA_W = 64;
  localparam int HAWK_AXI_STRB_W = HAWK_AXI_DATA_W / 8;

  typedef struct packed {
    logic [HAWK_AXI_ADDR_W-1:0] addr;
    logic [HAWK_AXI_DATA_W-1:0] data;
    logic [HAWK_AXI_STRB_W-1:0] strb;
    logic                       awvalid;
    logic                       wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic [1:0] bresp;
    logic       bvalid;
  } axi_wr_resppkt_t;

  localparam int HAWK_WRARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    WARB_IDLE   = 2'd0,
    WARB_XFER   = 2'd1,
    WARB_WAIT_B = 2'd2
  } warb_state_e;

  // Snapshot exported to the stall_debug probes.
  typedef struct packed {
    warb_state_e                   state;
    logic [HAWK_WRARB_MAX_REQ-1:0] gnt;
    logic [15:0]                   err_cnt;
  } debug_wrarb_t;

endpackage

// File: rtl/hawk_rr_picker.sv
// Combinational round-robin picker: one-hot choice of the first set request at or after ptr_i.
module hawk_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] pick_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // One extra sum bit so ptr+k never overflows before the wrap compare.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Round-robin sharing of the hawk_axiwr_master port; one write outstanding, grant held
// from AW/W acceptance until B, which is returned to the owner only.
module hawk_axiwr_arb
  import hacd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  axi_wr_reqpkt_t  [NUM_REQ-1:0]       req_pkt_i,
  output axi_wr_rdypkt_t  [NUM_REQ-1:0]       rdy_pkt_o,
  output axi_wr_resppkt_t [NUM_REQ-1:0]       resp_pkt_o,
  output axi_wr_reqpkt_t                      mst_req_o,
  input  axi_wr_rdypkt_t                      mst_rdy_i,
  input  axi_wr_resppkt_t                     mst_resp_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic                                busy_o,
  output logic [CNT_W-1:0]                    err_cnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = WARB_IDLE;
  localparam logic [1:0] S_XFER   = WARB_XFER;
  localparam logic [1:0] S_WAIT_B = WARB_WAIT_B;

  logic [1:0]         state_q,   state_d;
  logic [PW-1:0]      rr_ptr_q,  rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q,     gnt_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q,  w_done_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]      g_idx;
  axi_wr_reqpkt_t     own_req;
  logic               aw_fire, w_fire, aw_all, w_all;
  logic               b_take, err_inc;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec[i] = req_pkt_i[i].awvalid;
    end
  end

  hawk_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .req_i  (req_vec),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) g_idx = PW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_cnt_d  = err_cnt_q;
    mst_req_o  = '0;
    rdy_pkt_o  = '0;
    resp_pkt_o = '0;
    own_req    = req_pkt_i[g_idx];
    aw_fire    = 1'b0;
    w_fire     = 1'b0;
    aw_all     = 1'b0;
    w_all      = 1'b0;
    b_take     = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A response with nobody waiting for it is dropped but counted.
        err_inc = mst_resp_i.bvalid;
        if (|pick) begin
          gnt_d   = pick;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        mst_req_o                 = own_req;
        mst_req_o.awvalid         = own_req.awvalid & ~aw_done_q;
        mst_req_o.wvalid          = own_req.wvalid  & ~w_done_q;
        rdy_pkt_o[g_idx].awready  = mst_rdy_i.awready & ~aw_done_q;
        rdy_pkt_o[g_idx].wready   = mst_rdy_i.wready  & ~w_done_q;
        aw_fire   = own_req.awvalid & ~aw_done_q & mst_rdy_i.awready;
        w_fire    = own_req.wvalid  & ~w_done_q  & mst_rdy_i.wready;
        aw_all    = aw_done_q | aw_fire;
        w_all     = w_done_q  | w_fire;
        aw_done_d = aw_all;
        w_done_d  = w_all;
        if (aw_all && w_all) begin
          if (mst_resp_i.bvalid) b_take  = 1'b1;
          else                   state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        b_take = mst_resp_i.bvalid;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (b_take) begin
      resp_pkt_o[g_idx] = mst_resp_i;
      err_inc           = (mst_resp_i.bresp != 2'b00);
      gnt_d             = '0;
      aw_done_d         = 1'b0;
      w_done_d          = 1'b0;
      state_d           = S_IDLE;
      rr_ptr_d          = (g_idx == PW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
    end

    if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q != S_IDLE);
  assign err_cnt_o = err_cnt_q;

endmodule
